// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: sequencer for a bit-serial ALU.
// Takes one operation over a valid/ready request handshake. It runs a
// single-bit AND/OR/full-adder slice LSB-first, one bit per clock, and
// returns the result over a valid/ready response handshake.
// Optional build macro: SERIAL_ALU_LOGIC_FAST_EN. When it is defined,
// AND/OR skip the serial pass and their full-width result is loaded at
// accept time.
module serial_alu_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_SLT_FIX = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [5:0]       r_funct;
    logic             r_carry;
    logic             r_binv;
    logic             r_cin_msb;
    logic             r_cout;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic             r_overflow;
    logic             r_illegal;

    // Bit-slice signals
    logic w_a;
    logic w_b;
    logic w_sum;
    logic w_cout;
    logic w_bit;
    logic w_last;
    logic w_is_addsub;

    // Decode signals for the incoming request
    logic w_req_sub;
    logic w_req_legal;
    logic w_req_logic;
    logic w_accept;

    // Single-bit ALU slice on the current LSBs
    always_comb begin
        w_a    = r_a[0];
        w_b    = r_b[0] ^ r_binv;
        w_sum  = w_a ^ w_b ^ r_carry;
        w_cout = (w_a & w_b) | (w_a & r_carry) | (w_b & r_carry);
        case (r_funct)
            FUNCT_AND: w_bit = w_a & w_b;
            FUNCT_OR:  w_bit = w_a | w_b;
            default:   w_bit = w_sum;
        endcase
        w_last      = (r_cnt == CNT_W'(WIDTH - 1));
        w_is_addsub = (r_funct == FUNCT_ADD) || (r_funct == FUNCT_SUB);
    end

    // Request decode: subtract-style ops, legality, logic ops, handshake
    always_comb begin
        w_req_sub   = (funct == FUNCT_SUB) || (funct == FUNCT_SLT);
        w_req_logic = (funct == FUNCT_AND) || (funct == FUNCT_OR);
        w_req_legal = w_req_logic || w_req_sub || (funct == FUNCT_ADD);
        w_accept    = req_valid && r_req_ready && (r_state == ST_IDLE);
    end

    // Sequencer: accept, serial run, SLT fix-up, hold result until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_funct     <= '0;
            r_carry     <= 1'b0;
            r_binv      <= 1'b0;
            r_cin_msb   <= 1'b0;
            r_cout      <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_a         <= dataA;
                        r_b         <= dataB;
                        r_funct     <= funct;
                        r_carry     <= w_req_sub;
                        r_binv      <= w_req_sub;
                        r_cnt       <= '0;
                        r_res       <= '0;
                        r_overflow  <= 1'b0;
                        r_illegal   <= 1'b0;
                        if (!w_req_legal) begin
                            // Unknown op: answer immediately with zero data
                            r_illegal   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
`ifdef SERIAL_ALU_LOGIC_FAST_EN
                        else if (w_req_logic) begin
                            // Logic ops resolved in one step at full width
                            r_res       <= (funct == FUNCT_AND) ? (dataA & dataB)
                                                                : (dataA | dataB);
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
`endif
                        else begin
                            r_state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_res   <= {w_bit, r_res[WIDTH-1:1]};
                    r_carry <= w_cout;
                    if (w_last) begin
                        // MSB slice: carry-in vs carry-out flags signed overflow
                        r_cin_msb <= r_carry;
                        r_cout    <= w_cout;
                        if (r_funct == FUNCT_SLT) begin
                            r_state <= ST_SLT_FIX;
                        end else begin
                            r_overflow  <= w_is_addsub ? (r_carry ^ w_cout) : 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_SLT_FIX: begin
                    // Sign of A-B, corrected when the subtraction overflowed
                    r_res       <= {{(WIDTH-1){1'b0}}, r_res[WIDTH-1] ^ (r_cin_msb ^ r_cout)};
                    r_overflow  <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end

                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign dataOut   = r_res;
    assign overflow  = r_overflow;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl: requests push expected results from
// an arithmetic reference model; an independent monitor pops on each response.
module tb_serial_alu_ctrl;

    localparam int unsigned W = 32;

    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_SLT = 6'b101010;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [5:0]   funct;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] dataOut;
    logic         overflow;
    logic         illegal;

    typedef struct {
        logic [W-1:0] data;
        logic         ovf;
        logic         ill;
        int           lat;
        longint       acc;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   cur;
    int     checks   = 0;
    int     errors   = 0;
    int     issued   = 0;
    int     done_cnt = 0;
    longint cyc      = 0;
    bit     bp_hold  = 1'b0;
    bit     seen     = 1'b0;
    bit     post     = 1'b0;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .funct     (funct),
        .dataA     (dataA),
        .dataB     (dataB),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .dataOut   (dataOut),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: two's-complement arithmetic and signed compare.
    // Latency is counted in clock edges after the accept edge, so the
    // single-cycle paths show rsp_valid in the cycle right after accept.
    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.data = '0;
        e.ovf  = 1'b0;
        e.ill  = 1'b0;
        e.lat  = W;
        e.acc  = 0;
        case (f)
            F_AND: begin
                e.data = a & b;
`ifdef SERIAL_ALU_LOGIC_FAST_EN
                e.lat = 0;
`endif
            end
            F_OR: begin
                e.data = a | b;
`ifdef SERIAL_ALU_LOGIC_FAST_EN
                e.lat = 0;
`endif
            end
            F_ADD: begin
                e.data = a + b;
                e.ovf  = (a[W-1] == b[W-1]) && (e.data[W-1] != a[W-1]);
            end
            F_SUB: begin
                e.data = a - b;
                e.ovf  = (a[W-1] != b[W-1]) && (e.data[W-1] != a[W-1]);
            end
            F_SLT: begin
                e.data = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
                e.lat  = W + 1;
            end
            default: begin
                e.ill = 1'b1;
                e.lat = 0;
            end
        endcase
        return e;
    endfunction

    // Response side: random backpressure unless a test holds it low
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on each new response and checks holding
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
            post = 1'b0;
        end else begin
            if (post) begin
                chk("idle_rsp_valid", W'(rsp_valid), W'(0));
                chk("idle_req_ready", W'(req_ready), W'(1));
                post = 1'b0;
            end else if (rsp_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got dataOut %h with empty scoreboard", dataOut);
                        cur.data = dataOut;
                        cur.ovf  = overflow;
                        cur.ill  = illegal;
                    end else begin
                        cur = sb_q.pop_front();
                        chk("dataOut", dataOut, cur.data);
                        chk("overflow", W'(overflow), W'(cur.ovf));
                        chk("illegal", W'(illegal), W'(cur.ill));
                        chk("latency", W'(cyc - cur.acc), W'(cur.lat));
                    end
                end else begin
                    chk("hold_dataOut", dataOut, cur.data);
                    chk("hold_overflow", W'(overflow), W'(cur.ovf));
                end
                chk("done_req_ready", W'(req_ready), W'(0));
                if (rsp_ready) begin
                    seen = 1'b0;
                    post = 1'b1;
                    done_cnt++;
                end
            end else if (sb_q.size() != 0) begin
                chk("busy_req_ready", W'(req_ready), W'(0));
            end
        end
    end

    task automatic garbage();
        req_valid = 1'($urandom_range(0, 1));
        funct     = 6'($urandom);
        dataA     = $urandom;
        dataB     = $urandom;
    endtask

    task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        bit   took;
        int   n;
        e = model(f, a, b);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        funct     = f;
        dataA     = a;
        dataB     = b;
        took      = 1'b0;
        n         = 0;
        while (!took && n < 100) begin
            @(negedge clk);
            took = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready %b required 1", req_ready);
            req_valid = 1'b0;
        end else begin
            e.acc = cyc;
            sb_q.push_back(e);
            issued++;
            garbage();
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt < issued && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (done_cnt < issued) garbage();
            else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        if (done_cnt < issued) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: responses %0d required %0d", done_cnt, issued);
            issued = done_cnt;
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] f_tab [5];
        logic [5:0] f;
        int         n;
        f_tab[0] = F_AND;
        f_tab[1] = F_OR;
        f_tab[2] = F_ADD;
        f_tab[3] = F_SUB;
        f_tab[4] = F_SLT;

        reset     = 1'b1;
        req_valid = 1'b0;
        funct     = '0;
        dataA     = '0;
        dataB     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", W'(req_ready), W'(0));
        chk("rst_rsp_valid", W'(rsp_valid), W'(0));
        chk("rst_dataOut", dataOut, W'(0));
        chk("rst_flags", W'({overflow, illegal}), W'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_req_ready", W'(req_ready), W'(1));

        // Directed operations
        do_op(F_ADD, 32'h0000_0005, 32'h0000_0003); wait_done();
        do_op(F_SUB, 32'h8000_0000, 32'h0000_0001); wait_done();
        do_op(F_SUB, 32'h0000_0005, 32'h0000_0005); wait_done();
        do_op(F_SLT, 32'hFFFF_FFFF, 32'h0000_0001); wait_done();
        do_op(F_SLT, 32'h7FFF_FFFF, 32'h8000_0000); wait_done();
        do_op(F_SLT, 32'h8000_0000, 32'h7FFF_FFFF); wait_done();
        do_op(F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00); wait_done();
        do_op(F_OR,  32'hF0F0_F0F0, 32'hFF00_FF00); wait_done();
        do_op(6'b000000, 32'h1234_5678, 32'h9ABC_DEF0); wait_done();
        do_op(F_ADD, 32'h7FFF_FFFF, 32'h0000_0001); wait_done();

        // Backpressure: hold the response for 5 cycles while inputs churn
        bp_hold = 1'b1;
        do_op(F_ADD, 32'h1111_1111, 32'h2222_2222);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk);
            #1;
            garbage();
            n++;
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            garbage();
        end
        bp_hold = 1'b0;
        wait_done();

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 5);
            if (n == 5) f = 6'($urandom);
            else f = f_tab[n];
            do_op(f, rand_operand(), rand_operand());
            wait_done();
        end

        // Reset at counter==10 of an ADD: immediate clear, no response
        do_op(F_ADD, 32'hFFFF_0F0F, 32'h0F0F_FFFF);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_rsp_valid", W'(rsp_valid), W'(0));
        chk("async_rst_dataOut", dataOut, W'(0));
        chk("async_rst_flags", W'({overflow, illegal}), W'(0));
        chk("async_rst_req_ready", W'(req_ready), W'(0));
        sb_q.delete();
        issued = done_cnt;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_idle_req_ready", W'(req_ready), W'(1));
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("no_rsp_after_rst", W'(rsp_valid), W'(0));

        // One more op to show normal service resumed
        do_op(F_SUB, 32'h0000_0003, 32'h0000_0007); wait_done();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
